vote_entry_ctrl: RTL

- Sequences voter keypad entry for the ballot unit and owns the two candidate-digit registers that feed the two 7-segment decoder instances.
- Collects two decimal digits, or a blank-vote ("branco") selection; supports correction ("corrige") and confirmation ("confirma").
- Emits a one-cycle vote record and then holds a lockout period before accepting the next voter.
- Sits between the keypad debouncer/encoder and the tally counter and display decoders.

---
 rtl/vote_pkg.sv | 28 ++
 rtl/vote_hold_timer.sv | 29 ++
 rtl/vote_entry_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the ballot keypad entry controller.
package vote_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ONE,
    TWO,
    BLANK,
    DONE
  } state_e;

  localparam logic [3:0] KEY_BRANCO   = 4'hA;
  localparam logic [3:0] KEY_CORRIGE  = 4'hB;
  localparam logic [3:0] KEY_CONFIRMA = 4'hC;

  localparam logic [3:0] SEG_BLANK      = 4'hF;
  localparam logic [3:0] SEG_UNDERSCORE = 4'hD;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  // Two decimal digits to a binary candidate number (0-99 fits in 7 bits).
  function automatic logic [6:0] vote_value(input logic [3:0] tens, input logic [3:0] units);
    return (7'(tens) * 7'd10) + 7'(units);
  endfunction

endpackage

// File: rtl/vote_hold_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module vote_hold_timer #(
  parameter int unsigned     Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= ResetVal;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vote_entry_ctrl.sv
// Voter keypad entry sequencer: two digits or blank vote, correct/confirm, then lockout.
// Optional build macro CURSOR_BLINK_EN makes the awaiting digit position blink.
module vote_entry_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned DONE_HOLD = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] dig1_code,
  output logic [3:0] dig2_code,
  output logic       vote_valid,
  output logic       vote_blank,
  output logic [6:0] vote_number,
  output logic       busy
);

  localparam int unsigned      HoldW    = $clog2(DONE_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(DONE_HOLD - 1);

  if (DONE_HOLD < 1) begin : g_bad_done_hold
    $error("DONE_HOLD must be at least 1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  state_e     state_q, state_d;
  logic [3:0] d1_q, d1_d, d2_q, d2_d;
  logic       confirm_ok;
  logic       hold_zero;
  logic [3:0] cursor_code;
  logic [3:0] dig1_d, dig2_d;

  // State and digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  // Next-state and digit capture from keypad strobes.
  always_comb begin
    state_d    = state_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    confirm_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            d1_d    = key_code;
            state_d = ONE;
          end else if (key_code == KEY_BRANCO) begin
            state_d = BLANK;
          end
        end
      end
      ONE: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            d2_d    = key_code;
            state_d = TWO;
          end else if (key_code == KEY_CORRIGE) begin
            d1_d    = 4'd0;
            state_d = IDLE;
          end
        end
      end
      TWO: begin
        if (key_valid) begin
          if (key_code == KEY_CORRIGE) begin
            d1_d    = 4'd0;
            d2_d    = 4'd0;
            state_d = IDLE;
          end else if (key_code == KEY_CONFIRMA) begin
            confirm_ok = 1'b1;
            state_d    = DONE;
          end
        end
      end
      BLANK: begin
        if (key_valid) begin
          if (key_code == KEY_CONFIRMA) begin
            confirm_ok = 1'b1;
            state_d    = DONE;
          end else if (key_code == KEY_CORRIGE) begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        // Keys are ignored here, including one arriving on the exit cycle.
        if (hold_zero) begin
          d1_d    = 4'd0;
          d2_d    = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  vote_hold_timer #(
    .Width    (HoldW),
    .ResetVal ('0)
  ) u_done_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     ((state_d == DONE) && (state_q != DONE)),
    .load_val_i (HoldLoad),
    .dec_i      (state_q == DONE),
    .zero_o     (hold_zero)
  );

`ifdef CURSOR_BLINK_EN
  localparam int unsigned      BlinkW    = $clog2(BLINK_DIV + 1);
  localparam logic [BlinkW-1:0] BlinkLoad = BlinkW'(BLINK_DIV - 1);

  logic blink_on_q, blink_on_d, blink_load, blink_zero;

  // Phase restarts "on" at every state change, otherwise toggles each BLINK_DIV cycles.
  always_comb begin
    blink_on_d = blink_on_q;
    blink_load = 1'b0;
    if (state_d != state_q) begin
      blink_on_d = 1'b1;
      blink_load = 1'b1;
    end else if (blink_zero) begin
      blink_on_d = ~blink_on_q;
      blink_load = 1'b1;
    end
  end

  // Blink phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_on_q <= 1'b1;
    end else begin
      blink_on_q <= blink_on_d;
    end
  end

  vote_hold_timer #(
    .Width    (BlinkW),
    .ResetVal (BlinkLoad)
  ) u_blink_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (blink_load),
    .load_val_i (BlinkLoad),
    .dec_i      (1'b1),
    .zero_o     (blink_zero)
  );

  assign cursor_code = blink_on_d ? SEG_UNDERSCORE : SEG_BLANK;
`else
  assign cursor_code = SEG_UNDERSCORE;
`endif

  // Display codes derived from the upcoming state so they land with it.
  always_comb begin
    dig1_d = SEG_BLANK;
    dig2_d = SEG_BLANK;
    case (state_d)
      IDLE: begin
        dig1_d = cursor_code;
        dig2_d = SEG_UNDERSCORE;
      end
      ONE: begin
        dig1_d = d1_d;
        dig2_d = cursor_code;
      end
      TWO: begin
        dig1_d = d1_d;
        dig2_d = d2_d;
      end
      default: begin
        dig1_d = SEG_BLANK;
        dig2_d = SEG_BLANK;
      end
    endcase
  end

  // Registered outputs; vote record fields only change with a new vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig1_code   <= SEG_UNDERSCORE;
      dig2_code   <= SEG_UNDERSCORE;
      vote_valid  <= 1'b0;
      vote_blank  <= 1'b0;
      vote_number <= 7'd0;
      busy        <= 1'b0;
    end else begin
      dig1_code  <= dig1_d;
      dig2_code  <= dig2_d;
      vote_valid <= confirm_ok;
      busy       <= (state_d == DONE);
      if (confirm_ok) begin
        vote_blank  <= (state_q == BLANK);
        vote_number <= (state_q == BLANK) ? 7'd0 : vote_value(d1_q, d2_q);
      end
    end
  end

endmodule
